instr_register_alu: RTL and testbench

//  Parametrised successor to the instruction register.
//  - Stores DEPTH instruction words {opcode, operand_a, operand_b}.
//  - Computes each word's result in a 2-stage write pipeline and stores it with the word.
//  - Read port is registered, with a valid flag, a divide-by-zero error flag and write-to-read forwarding.
//  - Sits behind the tb_ifc test interface in the lab top level.

---
 rtl/instr_register_alu.sv | 191 +++++++++++++++++++
 tb/tb_instr_register_alu.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/instr_register_alu.sv
// ----------------------------------------------------------------------------
// instr_register_alu
//
// Purpose:
//   Instruction register with a built-in ALU. It holds DEPTH instruction words
//   {opcode, operand_a, operand_b}. Each word's result is computed in a
//   two-stage write pipeline and stored next to the word. The read port is
//   registered and reports valid, written and divide-by-zero error flags.
//
// Write/read timing (no stall, no backpressure):
//   load_en is sampled at edge N, when stage 1 captures the instruction.
//   The result is computed from the stage-1 registers, and the entry is
//   committed at edge N+1 with written=1.
//   read_en is sampled at edge N, and rd_* update at that same edge.
//   rd_valid is high for exactly the one cycle after a sampled read_en.
//   If a read at edge N hits the entry being committed at edge N, the read
//   returns the committing word (write-first forwarding).
//   A read that coincides with load_en to the same entry returns the old
//   contents.
//
// Parameters:
//   DEPTH  number of entries (power of two, >= 2); AW = $clog2(DEPTH)
//   OPW    signed operand width; the result width is RW = 2*OPW
//
// Configuration macro:
//   INSTR_REG_DIV_EN  when defined, DIV and MOD are implemented. When it is
//                     undefined, opcodes 6 and 7 store result 0 with err=1.
//
// Ports:
//   clk            in   single clock, rising edge
//   reset          in   synchronous, active-high; has priority over all else
//   load_en        in   write request
//   opcode         in   0 ZERO,1 PASSA,2 PASSB,3 ADD,4 SUB,5 MULT,6 DIV,7 MOD
//   operand_a      in   signed operand A
//   operand_b      in   signed operand B
//   write_pointer  in   target entry of the write
//   read_en        in   read request
//   read_pointer   in   entry to read
//   rd_valid       out  rd_* hold a completed read (one cycle)
//   rd_written     out  the entry read has been written since reset
//   rd_opcode      out  stored opcode
//   rd_operand_a   out  stored operand A
//   rd_operand_b   out  stored operand B
//   rd_result      out  stored signed result
//   rd_err         out  stored divide-by-zero flag
// ----------------------------------------------------------------------------
module instr_register_alu #(
    parameter int DEPTH = 32,
    parameter int OPW   = 32,
    localparam int AW   = $clog2(DEPTH),
    localparam int RW   = 2 * OPW
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load_en,
    input  logic [2:0]            opcode,
    input  logic signed [OPW-1:0] operand_a,
    input  logic signed [OPW-1:0] operand_b,
    input  logic [AW-1:0]         write_pointer,
    input  logic                  read_en,
    input  logic [AW-1:0]         read_pointer,
    output logic                  rd_valid,
    output logic                  rd_written,
    output logic [2:0]            rd_opcode,
    output logic signed [OPW-1:0] rd_operand_a,
    output logic signed [OPW-1:0] rd_operand_b,
    output logic signed [RW-1:0]  rd_result,
    output logic                  rd_err
);

    typedef struct packed {
        logic           written;
        logic [2:0]     opcode;
        logic [OPW-1:0] a;
        logic [OPW-1:0] b;
        logic [RW-1:0]  result;
        logic           err;
    } entry_t;

    entry_t mem [DEPTH];

    // Stage 1 holds the captured instruction.
    logic           s1_valid;
    logic [2:0]     s1_opcode;
    logic [OPW-1:0] s1_a;
    logic [OPW-1:0] s1_b;
    logic [AW-1:0]  s1_ptr;

    // Stage 2 computes the result combinationally from stage 1.
    // The word is committed at the next edge.
    logic signed [RW-1:0] a_ext;
    logic signed [RW-1:0] b_ext;
    logic signed [RW-1:0] alu_result;
    logic                 alu_err;
    entry_t               commit_entry;

    entry_t rd_q;
    logic   rd_valid_q;

    always_comb begin
        a_ext      = {{OPW{s1_a[OPW-1]}}, s1_a};
        b_ext      = {{OPW{s1_b[OPW-1]}}, s1_b};
        alu_result = '0;
        alu_err    = 1'b0;
        case (s1_opcode)
            3'd0: alu_result = '0;
            3'd1: alu_result = a_ext;
            3'd2: alu_result = b_ext;
            3'd3: alu_result = a_ext + b_ext;
            3'd4: alu_result = a_ext - b_ext;
            // Both operands are extended to RW bits, so the low RW bits of
            // the product are the full product.
            3'd5: alu_result = a_ext * b_ext;
`ifdef INSTR_REG_DIV_EN
            // The division is done at RW bits, so min / -1 = +2^(OPW-1)
            // does not overflow. A zero divisor is caught before the divider
            // is used.
            3'd6: begin
                if (b_ext == '0) alu_err = 1'b1;
                else             alu_result = a_ext / b_ext;
            end
            3'd7: begin
                if (b_ext == '0) alu_err = 1'b1;
                else             alu_result = a_ext % b_ext;
            end
`else
            3'd6: alu_err = 1'b1;
            3'd7: alu_err = 1'b1;
`endif
            default: alu_result = '0;
        endcase

        commit_entry.written = 1'b1;
        commit_entry.opcode  = s1_opcode;
        commit_entry.a       = s1_a;
        commit_entry.b       = s1_b;
        commit_entry.result  = alu_result;
        commit_entry.err     = alu_err;
    end

    // Stage-1 capture
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid  <= 1'b0;
            s1_opcode <= '0;
            s1_a      <= '0;
            s1_b      <= '0;
            s1_ptr    <= '0;
        end else begin
            s1_valid <= load_en;
            if (load_en) begin
                s1_opcode <= opcode;
                s1_a      <= operand_a;
                s1_b      <= operand_b;
                s1_ptr    <= write_pointer;
            end
        end
    end

    // Storage commit. Reset drops any word still in flight in stage 1.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (s1_valid) begin
            mem[s1_ptr] <= commit_entry;
        end
    end

    // Registered read with write-first forwarding from the commit stage
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_q       <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= read_en;
            if (read_en) begin
                if (s1_valid && (s1_ptr == read_pointer)) rd_q <= commit_entry;
                else                                      rd_q <= mem[read_pointer];
            end
        end
    end

    assign rd_valid     = rd_valid_q;
    assign rd_written   = rd_q.written;
    assign rd_opcode    = rd_q.opcode;
    assign rd_operand_a = rd_q.a;
    assign rd_operand_b = rd_q.b;
    assign rd_result    = rd_q.result;
    assign rd_err       = rd_q.err;

endmodule

// File: tb/tb_instr_register_alu.sv
module tb_instr_register_alu;

    localparam int DEPTH = 32;
    localparam int OPW   = 32;
    localparam int AW    = $clog2(DEPTH);
    localparam int RW    = 2 * OPW;

    localparam logic signed [OPW-1:0] MIN_A = {1'b1, {(OPW-1){1'b0}}};

    logic                  clk;
    logic                  reset;
    logic                  load_en;
    logic [2:0]            opcode;
    logic signed [OPW-1:0] operand_a;
    logic signed [OPW-1:0] operand_b;
    logic [AW-1:0]         write_pointer;
    logic                  read_en;
    logic [AW-1:0]         read_pointer;
    logic                  rd_valid;
    logic                  rd_written;
    logic [2:0]            rd_opcode;
    logic signed [OPW-1:0] rd_operand_a;
    logic signed [OPW-1:0] rd_operand_b;
    logic signed [RW-1:0]  rd_result;
    logic                  rd_err;

    int vectors;
    int miscompares;

    instr_register_alu #(.DEPTH(DEPTH), .OPW(OPW)) dut (
        .clk           (clk),
        .reset         (reset),
        .load_en       (load_en),
        .opcode        (opcode),
        .operand_a     (operand_a),
        .operand_b     (operand_b),
        .write_pointer (write_pointer),
        .read_en       (read_en),
        .read_pointer  (read_pointer),
        .rd_valid      (rd_valid),
        .rd_written    (rd_written),
        .rd_opcode     (rd_opcode),
        .rd_operand_a  (rd_operand_a),
        .rd_operand_b  (rd_operand_b),
        .rd_result     (rd_result),
        .rd_err        (rd_err)
    );

    // clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Returns 1 time unit after the rising edge, so outputs are stable and
    // new inputs set here are sampled at the following edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one write for a single edge.
    task automatic do_write(input logic [2:0] op, input logic signed [OPW-1:0] a,
                            input logic signed [OPW-1:0] b, input logic [AW-1:0] ptr);
        load_en       = 1'b1;
        opcode        = op;
        operand_a     = a;
        operand_b     = b;
        write_pointer = ptr;
        tick();
        load_en = 1'b0;
    endtask

    task automatic do_read(input logic [AW-1:0] ptr);
        read_en      = 1'b1;
        read_pointer = ptr;
        tick();
        read_en = 1'b0;
    endtask

    // Write one word, let it commit, then read it back.
    task automatic write_then_read(input logic [2:0] op, input logic signed [OPW-1:0] a,
                                   input logic signed [OPW-1:0] b, input logic [AW-1:0] ptr);
        do_write(op, a, b, ptr);
        tick();
        do_read(ptr);
    endtask

    task automatic chk_word(input string tag, input logic signed [RW-1:0] exp_res,
                            input logic exp_err);
        chk({tag, ".valid"},   RW'(rd_valid),   RW'(1));
        chk({tag, ".written"}, RW'(rd_written), RW'(1));
        chk({tag, ".result"},  rd_result,       exp_res);
        chk({tag, ".err"},     RW'(rd_err),     RW'(exp_err));
    endtask

    initial begin
        vectors       = 0;
        miscompares   = 0;
        reset         = 1'b1;
        load_en       = 1'b0;
        opcode        = '0;
        operand_a     = '0;
        operand_b     = '0;
        write_pointer = '0;
        read_en       = 1'b0;
        read_pointer  = '0;

        // Reset for two cycles.
        tick();
        tick();
        chk("reset.rd_valid",  RW'(rd_valid),  RW'(0));
        chk("reset.rd_result", rd_result,      '0);
        reset = 1'b0;

        // Every entry reads back as cleared and never written.
        for (int i = 0; i < DEPTH; i++) begin
            do_read(AW'(i));
            chk("clr.valid",   RW'(rd_valid),     RW'(1));
            chk("clr.written", RW'(rd_written),   RW'(0));
            chk("clr.opcode",  RW'(rd_opcode),    RW'(0));
            chk("clr.a",       RW'(rd_operand_a), RW'(0));
            chk("clr.b",       RW'(rd_operand_b), RW'(0));
            chk("clr.result",  rd_result,         '0);
            chk("clr.err",     RW'(rd_err),       RW'(0));
        end
        tick();
        chk("idle.valid", RW'(rd_valid), RW'(0));

        // ADD 5 + -7 = -2, read two cycles after load_en.
        write_then_read(3'd3, 32'sd5, -32'sd7, AW'(3));
        chk_word("add", -64'sd2, 1'b0);
        chk("add.opcode", RW'(rd_opcode), RW'(3));
        chk("add.a", RW'(rd_operand_a), RW'(5));
        chk("add.b", {{OPW{1'b1}}, rd_operand_b}, 64'hFFFF_FFFF_FFFF_FFF9);
        // Without read_en the fields hold and valid drops.
        tick();
        chk("hold.valid",  RW'(rd_valid), RW'(0));
        chk("hold.result", rd_result,     -64'sd2);

        // MULT min*min = 2^62.
        write_then_read(3'd5, MIN_A, MIN_A, AW'(5));
        chk_word("mult", 64'sh4000_0000_0000_0000, 1'b0);
        // SUB min - 1 = -2^31 - 1, no wrap at RW bits.
        write_then_read(3'd4, MIN_A, 32'sd1, AW'(10));
        chk_word("sub", 64'shFFFF_FFFF_7FFF_FFFF, 1'b0);
        // PASSA, ZERO and PASSB.
        write_then_read(3'd1, -32'sd123, 32'sd4, AW'(11));
        chk_word("passa", -64'sd123, 1'b0);
        write_then_read(3'd0, 32'sd77, 32'sd4, AW'(12));
        chk_word("zero", 64'sd0, 1'b0);
        write_then_read(3'd2, 32'sd1, 32'sd9, AW'(13));
        chk_word("passb", 64'sd9, 1'b0);

`ifdef INSTR_REG_DIV_EN
        write_then_read(3'd6, -32'sd7, 32'sd2, AW'(7));
        chk_word("div", -64'sd3, 1'b0);
        write_then_read(3'd7, -32'sd7, 32'sd2, AW'(8));
        chk_word("mod", -64'sd1, 1'b0);
        write_then_read(3'd6, 32'sd8, 32'sd0, AW'(14));
        chk_word("div0", 64'sd0, 1'b1);
        write_then_read(3'd6, MIN_A, -32'sd1, AW'(15));
        chk_word("divmin", 64'sh0000_0000_8000_0000, 1'b0);
        write_then_read(3'd7, MIN_A, -32'sd1, AW'(16));
        chk_word("modmin", 64'sd0, 1'b0);
`else
        write_then_read(3'd6, 32'sd8, 32'sd2, AW'(7));
        chk_word("div_off", 64'sd0, 1'b1);
        write_then_read(3'd7, 32'sd8, 32'sd3, AW'(8));
        chk_word("mod_off", 64'sd0, 1'b1);
`endif

        // Back-to-back writes to the same entry: the last one wins.
        do_write(3'd1, 32'sd1, 32'sd0, AW'(9));
        do_write(3'd1, 32'sd2, 32'sd0, AW'(9));
        tick();
        do_read(AW'(9));
        chk_word("b2b", 64'sd2, 1'b0);

        // Hazards on entry 4, which has never been written.
        // A read at the same edge as load_en returns the old contents.
        load_en       = 1'b1;
        opcode        = 3'd1;
        operand_a     = 32'sd11;
        operand_b     = 32'sd0;
        write_pointer = AW'(4);
        read_en       = 1'b1;
        read_pointer  = AW'(4);
        tick();
        load_en = 1'b0;
        chk("haz_old.valid",   RW'(rd_valid),   RW'(1));
        chk("haz_old.written", RW'(rd_written), RW'(0));
        chk("haz_old.result",  rd_result,       '0);
        // A read at the commit edge is forwarded the committing word.
        tick();
        read_en = 1'b0;
        chk_word("haz_fwd", 64'sd11, 1'b0);

        // A write in flight when reset arrives is dropped.
        do_write(3'd1, 32'sd55, 32'sd0, AW'(6));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst.rd_valid",  RW'(rd_valid), RW'(0));
        chk("rst.rd_result", rd_result,     '0);
        tick();
        do_read(AW'(6));
        chk("drop.valid",   RW'(rd_valid),   RW'(1));
        chk("drop.written", RW'(rd_written), RW'(0));
        chk("drop.result",  rd_result,       '0);
        do_read(AW'(3));
        chk("rst3.written", RW'(rd_written), RW'(0));
        chk("rst3.result",  rd_result,       '0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
